pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter PC_W, default 16: PC/address width.
REQ-002 SHALL have parameter OFF_W, default 9: signed branch-offset width, in halfwords.
REQ-003 SHALL have parameter RAS_DEPTH, default 4: return-address-stack entries (power of 2).
REQ-004 SHALL have parameter CNT_W, default 16: taken-branch counter width.
REQ-005 SHALL have parameter RESET_VEC, default 0: PC value after reset.
REQ-006 clk  in  1  sole clock, rising edge.
REQ-007 rst_n  in  1  reset, synchronous, active-low.
REQ-008 stall  in  1  hold PC.
REQ-009 hlt  in  1  halt request.
REQ-010 br_valid  in  1  branch resolving this cycle.
REQ-011 br_cond  in  3  condition code.
REQ-012 br_reg  in  1  1 = target from rs_data; 0 = PC-relative.
REQ-013 br_call / br_ret  in  1 each  call / return hints.
REQ-014 br_off  in  OFF_W  signed offset.
REQ-015 br_pc2  in  PC_W  branch instruction address + 2.
REQ-016 rs_data  in  PC_W  register target.
REQ-017 flags  in  3  {N,V,Z}.
REQ-018 pc  out  PC_W  registered fetch PC.
REQ-019 pc_plus2  out  PC_W  pc+2, combinational.
REQ-020 flush  out  1  registered one-cycle pulse after a taken redirect.
REQ-021 halted  out  1  registered; high in HALT.
REQ-022 taken_cnt  out  CNT_W  saturating count of taken branches.

Function
REQ-023 Condition met SHALL be: 000 Z=0; 001 Z=1; 010 Z=0&N=0; 011 N=1; 100 Z=1 | (Z=0&N=0); 101 N=1 | Z=1; 110 V=1; 111 always.
REQ-024 taken SHALL be br_valid & condition met & state RUN.
REQ-025 Relative target SHALL be br_pc2 + (sign-extended br_off << 1), modulo 2^PC_W.
REQ-026 Register target SHALL be rs_data, except returns per REQ-036.
REQ-027 FSM states SHALL be RUN and HALT; only reset leaves HALT.
REQ-028 RUN next-PC priority: taken -> target; else hlt -> hold PC, go HALT; else stall -> hold; else pc+2.
REQ-029 Taken branch SHALL override stall and hlt in the same cycle; hlt then ignored.
REQ-030 Redirect latency SHALL be one cycle: target on pc and flush=1 the cycle after sampling taken.
REQ-031 In HALT, pc SHALL hold, flush=0, br_valid ignored.
REQ-032 taken_cnt SHALL increment per taken branch and saturate at all-ones.
REQ-033 pc_plus2 SHALL wrap modulo 2^PC_W (all-ones-1 +2 -> 0).

Reset
REQ-034 When rst_n=0 at a clock edge: pc=RESET_VEC, state RUN, flush=0, halted=0, taken_cnt=0, RAS emptied; overrides every other input, including mid-redirect and in HALT.

Configuration
REQ-035 Macro PC_SEQ_RAS_EN SHALL compile in the return-address stack.
REQ-036 With it: taken call pushes br_pc2; taken return with RAS non-empty pops and targets the popped value, ignoring rs_data; return on empty targets rs_data; push when full overwrites oldest (circular); call and return together replace top, target old top.
REQ-037 Without it: br_call/br_ret ports present, ignored; returns follow REQ-026.

Structure
REQ-038 Package pc_seq_pkg SHALL hold condition-code constants (COND_NE..COND_UNC) and state type {ST_RUN, ST_HALT}.
REQ-039 Condition decode SHALL be sub-module pc_seq_cond (combinational: br_cond, flags -> met).

Verification
REQ-040 Reset, idle 3 cycles -> pc 0x0000,0x0002,0x0004,0x0006; taken_cnt=0.
REQ-041 br_pc2=0x0010, br_off=-3, cond=111 -> next pc=0x000A, flush=1 one cycle, taken_cnt=1.
REQ-042 cond=001, Z=0, with stall=1 -> pc holds, no flush; same with Z=1 -> pc=target despite stall.
REQ-043 hlt=1 at pc=0x0020 -> halted=1, pc=0x0020 held 10 cycles; rst_n=0 one edge -> pc=0, RUN.
REQ-044 (PC_SEQ_RAS_EN) calls from br_pc2=0x0100,0x0200 then two returns (rs_data=0xBEEF) -> targets 0x0200,0x0100; third return -> 0xBEEF.
REQ-045 CNT_W=2, four taken branches -> taken_cnt 1,2,3,3.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared definitions for the PC sequencer: condition codes and sequencer states.
package pc_seq_pkg;

    localparam logic [2:0] COND_NE  = 3'b000;
    localparam logic [2:0] COND_EQ  = 3'b001;
    localparam logic [2:0] COND_GT  = 3'b010;
    localparam logic [2:0] COND_LT  = 3'b011;
    localparam logic [2:0] COND_GE  = 3'b100;
    localparam logic [2:0] COND_LE  = 3'b101;
    localparam logic [2:0] COND_VS  = 3'b110;
    localparam logic [2:0] COND_UNC = 3'b111;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

endpackage

// File: rtl/pc_seq_cond.sv
// Branch condition decode: maps a 3-bit condition code and {N,V,Z} flags to "met".
module pc_seq_cond
    import pc_seq_pkg::*;
(
    input  logic [2:0] br_cond,
    input  logic [2:0] flags,
    output logic       met
);

    logic n, v, z;
    assign {n, v, z} = flags;

    always_comb begin
        met = 1'b0;
        case (br_cond)
            COND_NE:  met = !z;
            COND_EQ:  met = z;
            COND_GT:  met = !z && !n;
            COND_LT:  met = n;
            COND_GE:  met = z || (!z && !n);
            COND_LE:  met = n || z;
            COND_VS:  met = v;
            COND_UNC: met = 1'b1;
            default:  met = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer with RUN/HALT FSM, branch redirect and taken-branch counter.
// Define PC_SEQ_RAS_EN to compile in the circular return-address stack (RAS_DEPTH >= 2).
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int              PC_W      = 16,
    parameter int              OFF_W     = 9,
    parameter int              RAS_DEPTH = 4,
    parameter int              CNT_W     = 16,
    parameter logic [PC_W-1:0] RESET_VEC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              hlt,
    input  logic              br_valid,
    input  logic [2:0]        br_cond,
    input  logic              br_reg,
    input  logic              br_call,
    input  logic              br_ret,
    input  logic [OFF_W-1:0]  br_off,
    input  logic [PC_W-1:0]   br_pc2,
    input  logic [PC_W-1:0]   rs_data,
    input  logic [2:0]        flags,
    output logic [PC_W-1:0]   pc,
    output logic [PC_W-1:0]   pc_plus2,
    output logic              flush,
    output logic              halted,
    output logic [CNT_W-1:0]  taken_cnt
);

    state_t           state, state_nxt;
    logic             met, taken, flush_nxt;
    logic [PC_W-1:0]  off_sx, rel_tgt, tgt, pc_nxt;

    pc_seq_cond u_cond (
        .br_cond (br_cond),
        .flags   (flags),
        .met     (met)
    );

    assign off_sx   = PC_W'($signed(br_off));
    assign rel_tgt  = br_pc2 + (off_sx << 1);
    assign taken    = br_valid && met && (state == ST_RUN);
    assign pc_plus2 = pc + PC_W'(2);

`ifdef PC_SEQ_RAS_EN
    localparam int RAS_AW = $clog2(RAS_DEPTH);
    localparam int RAS_CW = $clog2(RAS_DEPTH + 1);

    logic [PC_W-1:0]   ras [RAS_DEPTH];
    logic [RAS_AW-1:0] ras_sp;    // index of the current top entry
    logic [RAS_CW-1:0] ras_cnt;   // valid entries, saturates at RAS_DEPTH
    logic              ras_hit;

    assign ras_hit = br_ret && (ras_cnt != '0);
    // Any return leaves through the register path; a live RAS entry beats rs_data.
    assign tgt = ras_hit ? ras[ras_sp] : ((br_reg || br_ret) ? rs_data : rel_tgt);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ras_sp  <= '0;
            ras_cnt <= '0;
        end else if (taken) begin
            if (br_call && ras_hit) begin
                ras[ras_sp] <= br_pc2;
            end else if (br_call) begin
                ras[ras_sp + 1'b1] <= br_pc2;
                ras_sp             <= ras_sp + 1'b1;
                if (ras_cnt != RAS_CW'(RAS_DEPTH))
                    ras_cnt <= ras_cnt + 1'b1;
            end else if (ras_hit) begin
                ras_sp  <= ras_sp - 1'b1;
                ras_cnt <= ras_cnt - 1'b1;
            end
        end
    end
`else
    logic unused_hints;
    assign unused_hints = &{1'b0, br_call, br_ret};
    assign tgt = br_reg ? rs_data : rel_tgt;
`endif

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        flush_nxt = 1'b0;
        if (state == ST_RUN) begin
            if (taken) begin
                pc_nxt    = tgt;
                flush_nxt = 1'b1;
            end else if (hlt) begin
                state_nxt = ST_HALT;
            end else if (!stall) begin
                pc_nxt = pc_plus2;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_RUN;
            pc        <= RESET_VEC;
            flush     <= 1'b0;
            halted    <= 1'b0;
            taken_cnt <= '0;
        end else begin
            state  <= state_nxt;
            pc     <= pc_nxt;
            flush  <= flush_nxt;
            halted <= (state_nxt == ST_HALT);
            if (taken && (taken_cnt != '1))
                taken_cnt <= taken_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer; a second instance with CNT_W=2 checks counter saturation.
module tb_pc_sequencer;
    import pc_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, stall, hlt, br_valid, br_reg, br_call, br_ret;
    logic [2:0]  br_cond, flags;
    logic [8:0]  br_off;
    logic [15:0] br_pc2, rs_data;
    logic [15:0] pc, pc_plus2, pc_b, pc_plus2_b;
    logic        flush, halted, flush_b, halted_b;
    logic [15:0] taken_cnt;
    logic [1:0]  taken_cnt_b;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .hlt(hlt), .br_valid(br_valid),
        .br_cond(br_cond), .br_reg(br_reg), .br_call(br_call), .br_ret(br_ret),
        .br_off(br_off), .br_pc2(br_pc2), .rs_data(rs_data), .flags(flags),
        .pc(pc), .pc_plus2(pc_plus2), .flush(flush), .halted(halted), .taken_cnt(taken_cnt)
    );

    pc_sequencer #(.CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .stall(stall), .hlt(hlt), .br_valid(br_valid),
        .br_cond(br_cond), .br_reg(br_reg), .br_call(br_call), .br_ret(br_ret),
        .br_off(br_off), .br_pc2(br_pc2), .rs_data(rs_data), .flags(flags),
        .pc(pc_b), .pc_plus2(pc_plus2_b), .flush(flush_b), .halted(halted_b), .taken_cnt(taken_cnt_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // cond, {N,V,Z}, met
    logic [2:0] ct_cond [13] = '{3'd0,3'd0,3'd1,3'd2,3'd2,3'd3,3'd4,3'd4,3'd5,3'd5,3'd6,3'd6,3'd7};
    logic [2:0] ct_flag [13] = '{3'b000,3'b001,3'b001,3'b000,3'b100,3'b100,3'b001,3'b100,
                                 3'b001,3'b000,3'b010,3'b101,3'b111};
    logic       ct_met  [13] = '{1'b1,1'b0,1'b1,1'b1,1'b0,1'b1,1'b1,1'b0,1'b1,1'b0,1'b1,1'b0,1'b1};
    logic [1:0] sat_exp [4]  = '{2'd1,2'd2,2'd3,2'd3};

    initial begin
        logic [15:0] exp_pc;
        rst_n = 0; stall = 0; hlt = 0; br_valid = 0; br_reg = 0; br_call = 0; br_ret = 0;
        br_cond = 3'd0; flags = 3'd0; br_off = '0; br_pc2 = '0; rs_data = '0;

        // Reset state and free-running increment
        tick();
        chk("rst_pc", pc, 16'h0000);
        chk("rst_flush", flush, 0);
        chk("rst_halted", halted, 0);
        chk("rst_cnt", taken_cnt, 0);
        chk("rst_pc_plus2", pc_plus2, 16'h0002);
        rst_n = 1;
        tick(); chk("idle_pc1", pc, 16'h0002);
        tick(); chk("idle_pc2", pc, 16'h0004);
        tick(); chk("idle_pc3", pc, 16'h0006);
        chk("idle_cnt", taken_cnt, 0);

        // Relative backward branch: 0x0010 + (-3 << 1) = 0x000A
        br_valid = 1; br_cond = COND_UNC; br_pc2 = 16'h0010; br_off = 9'h1FD;
        tick();
        chk("rel_pc", pc, 16'h000A);
        chk("rel_flush", flush, 1);
        chk("rel_cnt", taken_cnt, 1);
        chk("rel_cnt_b", taken_cnt_b, 1);
        br_valid = 0;
        tick();
        chk("rel_after_pc", pc, 16'h000C);
        chk("rel_after_flush", flush, 0);

        // Not-taken under stall holds; taken overrides stall (target 0x0040 + 8)
        br_valid = 1; br_cond = COND_EQ; flags = 3'b000; stall = 1; br_pc2 = 16'h0040; br_off = 9'd4;
        tick();
        chk("stall_nt_pc", pc, 16'h000C);
        chk("stall_nt_flush", flush, 0);
        chk("stall_nt_cnt", taken_cnt, 1);
        flags = 3'b001;
        tick();
        chk("stall_tk_pc", pc, 16'h0048);
        chk("stall_tk_flush", flush, 1);
        chk("stall_tk_cnt", taken_cnt, 2);
        stall = 0; flags = 3'b000;

        // Relative target wrap: 0x0002 - 6 = 0xFFFC, then pc_plus2 wraps
        br_cond = COND_UNC; br_pc2 = 16'h0002; br_off = 9'h1FD;
        tick();
        chk("wrap_tgt", pc, 16'hFFFC);
        br_valid = 0;
        tick();
        chk("wrap_pc", pc, 16'hFFFE);
        chk("wrap_plus2", pc_plus2, 16'h0000);
        tick();
        chk("wrap_pc0", pc, 16'h0000);

        // Condition decode table via register-target branches
        exp_pc = 16'h0000;
        br_valid = 1; br_reg = 1;
        for (int i = 0; i < 13; i++) begin
            br_cond = ct_cond[i]; flags = ct_flag[i]; rs_data = 16'h0300 + 16'(i * 16);
            tick();
            exp_pc = ct_met[i] ? rs_data : exp_pc + 16'd2;
            chk($sformatf("cond%0d_f%0b", ct_cond[i], ct_flag[i]), pc, exp_pc);
        end

        // Taken beats hlt; then hlt enters HALT and everything is ignored
        hlt = 1; br_cond = COND_UNC; flags = 3'b000; rs_data = 16'h0020;
        tick();
        chk("hlt_tk_pc", pc, 16'h0020);
        chk("hlt_tk_flush", flush, 1);
        chk("hlt_tk_halted", halted, 0);
        br_valid = 0;
        tick();
        chk("halt_pc", pc, 16'h0020);
        chk("halt_halted", halted, 1);
        hlt = 0; br_valid = 1; rs_data = 16'h0500;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("halt_hold_pc%0d", i), pc, 16'h0020);
            chk($sformatf("halt_hold_flush%0d", i), flush, 0);
        end
        chk("halt_hold_halted", halted, 1);
        rst_n = 0;
        tick();
        chk("halt_rst_pc", pc, 16'h0000);
        chk("halt_rst_halted", halted, 0);
        chk("halt_rst_flush", flush, 0);
        chk("halt_rst_cnt", taken_cnt, 0);
        rst_n = 1; br_valid = 0;
        tick();
        chk("halt_rst_run", pc, 16'h0002);

        // Counter saturation on the 2-bit instance
        br_valid = 1;
        for (int k = 1; k <= 4; k++) begin
            rs_data = 16'(k * 16'h40);
            tick();
            chk($sformatf("sat_pc%0d", k), pc, 16'(k * 16'h40));
            chk($sformatf("sat_cnt%0d", k), taken_cnt, k);
            chk($sformatf("sat_cnt_b%0d", k), taken_cnt_b, sat_exp[k-1]);
        end

        // Return-address stack
        br_valid = 0; rst_n = 0;
        tick();
        rst_n = 1; br_valid = 1; br_reg = 0; br_off = '0; br_call = 1;
        br_pc2 = 16'h0100; tick(); chk("call1_pc", pc, 16'h0100);
        br_pc2 = 16'h0200; tick(); chk("call2_pc", pc, 16'h0200);
        br_call = 0; br_ret = 1; br_reg = 1; rs_data = 16'hBEEF;
`ifdef PC_SEQ_RAS_EN
        tick(); chk("ret1_pc", pc, 16'h0200);
        tick(); chk("ret2_pc", pc, 16'h0100);
        tick(); chk("ret3_pc", pc, 16'hBEEF);
        // Overflow keeps the newest four entries
        br_ret = 0; br_call = 1; br_reg = 0;
        for (int k = 1; k <= 5; k++) begin
            br_pc2 = 16'(k * 16'h1000);
            tick();
            chk($sformatf("ovf_call%0d", k), pc, 16'(k * 16'h1000));
        end
        br_call = 0; br_ret = 1; br_reg = 1;
        for (int k = 5; k >= 1; k--) begin
            tick();
            chk($sformatf("ovf_ret%0d", k), pc, (k == 1) ? 16'hBEEF : 16'(k * 16'h1000));
        end
        // Call+return together swaps the top entry
        br_ret = 0; br_call = 1; br_reg = 0; br_pc2 = 16'h0700;
        tick(); chk("swap_push", pc, 16'h0700);
        br_ret = 1; br_pc2 = 16'h0800;
        tick(); chk("swap_tgt", pc, 16'h0700);
        br_call = 0; br_reg = 1;
        tick(); chk("swap_pop", pc, 16'h0800);
        tick(); chk("swap_empty", pc, 16'hBEEF);
`else
        tick(); chk("ret1_pc", pc, 16'hBEEF);
        rs_data = 16'hCAFE;
        tick(); chk("ret2_pc", pc, 16'hCAFE);
        br_reg = 0; br_pc2 = 16'h0600; br_off = 9'd2;
        tick(); chk("ret_rel_pc", pc, 16'h0604);
`endif
        br_valid = 0; br_ret = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
